// File: rtl/rsa_engine_arbiter_if.sv
// Signal bundle for rsa_engine_arbiter: key load, two request ports, the tagged
// response channel and the engine start/done side. slave = arbiter, master = system.
interface rsa_engine_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             key_wr;
  logic [WIDTH-1:0] key_exp;
  logic [WIDTH-1:0] key_mod;
  logic             key_loaded;

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic [1:0]       rsp_err;

  logic             eng_start;
  logic [WIDTH-1:0] eng_plaintext;
  logic [WIDTH-1:0] eng_exp;
  logic [WIDTH-1:0] eng_mod;
  logic [WIDTH-1:0] eng_ciphertext;
  logic             eng_done;

  logic             busy;

  modport slave (
    input  key_wr, key_exp, key_mod,
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  rsp_ready, eng_ciphertext, eng_done,
    output key_loaded, req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_err,
    output eng_start, eng_plaintext, eng_exp, eng_mod, busy
  );

  modport master (
    output key_wr, key_exp, key_mod,
    output req0_valid, req0_data, req1_valid, req1_data,
    output rsp_ready, eng_ciphertext, eng_done,
    input  key_loaded, req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_err,
    input  eng_start, eng_plaintext, eng_exp, eng_mod, busy
  );
endinterface

// File: rtl/rsa_engine_arbiter.sv
// Shares one rsa_encryptor between two plaintext ports with round-robin grant,
// operand range check, engine timeout and a single tagged response channel.
module rsa_engine_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rsa_engine_arbiter_if.slave  bus
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_RANGE   = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             key_loaded_q, key_loaded_d;
  logic [WIDTH-1:0] key_exp_q, key_exp_d;
  logic [WIDTH-1:0] key_mod_q, key_mod_d;
  logic [WIDTH-1:0] pt_q, pt_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  err_e             rsp_err_q, rsp_err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             grant0, grant1;
  logic [WIDTH-1:0] sel_data;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    key_loaded_d = key_loaded_q;
    key_exp_d    = key_exp_q;
    key_mod_d    = key_mod_q;
    pt_d         = pt_q;
    id_d         = id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    cnt_d        = cnt_q;
    grant0       = 1'b0;
    grant1       = 1'b0;
    sel_data     = bus.req0_data;

    case (state_q)
      IDLE: begin
        // On a tie the port that was not served last wins.
        if (key_loaded_q) begin
          if (bus.req0_valid && (!bus.req1_valid || last_grant_q)) begin
            grant0 = 1'b1;
          end else if (bus.req1_valid) begin
            grant1 = 1'b1;
          end
        end

        if (grant0 || grant1) begin
          sel_data     = grant1 ? bus.req1_data : bus.req0_data;
          pt_d         = sel_data;
          id_d         = grant1;
          last_grant_d = grant1;
          if (sel_data >= key_mod_q) begin
            rsp_data_d = '0;
            rsp_err_d  = ERR_RANGE;
            state_d    = RESP;
          end else begin
            state_d    = START;
          end
        end else if (bus.key_wr && (bus.key_mod > WIDTH'(1))) begin
          key_exp_d    = bus.key_exp;
          key_mod_d    = bus.key_mod;
          key_loaded_d = 1'b1;
        end
      end

      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        // A done in the final counted cycle still wins over the timeout.
        if (bus.eng_done) begin
          rsp_data_d = bus.eng_ciphertext;
          rsp_err_d  = ERR_OK;
          state_d    = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = ERR_TIMEOUT;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      key_loaded_q <= 1'b0;
      key_exp_q    <= '0;
      key_mod_q    <= '0;
      pt_q         <= '0;
      id_q         <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= ERR_OK;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      key_loaded_q <= key_loaded_d;
      key_exp_q    <= key_exp_d;
      key_mod_q    <= key_mod_d;
      pt_q         <= pt_d;
      id_q         <= id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.key_loaded    = key_loaded_q;
  assign bus.req0_ready    = grant0;
  assign bus.req1_ready    = grant1;
  assign bus.rsp_valid     = (state_q == RESP);
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_id        = id_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.eng_start     = (state_q == START);
  assign bus.eng_plaintext = pt_q;
  assign bus.eng_exp       = key_exp_q;
  assign bus.eng_mod       = key_mod_q;
  assign bus.busy          = (state_q != IDLE);

endmodule
